// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Layout definitions shared by the systolic multiplier and its result writer.
// Both blocks take the matrix dimension and the element/flag bit positions from
// here, so the flattened result bus has exactly one definition.
//   max_dim()   : maximum matrix dimension for a given bus/operand width pair
//   elem_idx()  : slice index of element (r,c) in the flattened result bus
//   flag_idx()  : bit index of the overflow flag of element (r,c)
//   cnt_width() : width of a row/column counter (never below 1 bit)
//   wr_state_e  : result-writer FSM encoding
// -----------------------------------------------------------------------------
package matmul_pkg;

  function automatic int max_dim(input int bus_width, input int data_width);
    return bus_width / data_width;
  endfunction

  // Column-major: all rows of column 0 first, then column 1, ...
  function automatic int elem_idx(input int r, input int c, input int max_d);
    return c * max_d + r;
  endfunction

  function automatic int flag_idx(input int r, input int c, input int max_d);
    return r + c * max_d;
  endfunction

  function automatic int cnt_width(input int max_d);
    return (max_d > 1) ? $clog2(max_d) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/matmul_result_writer.sv
// -----------------------------------------------------------------------------
// matmul_result_writer
// Drains the systolic multiplier's result matrix into the result scratchpad.
// On a rising edge of finish_mul_i the valid (n+1)x(m+1) region, its overflow
// flags, the dimensions and the base address are captured into shadow
// registers; the elements are then written one per accepted beat in row-major
// order, and finish_write_o pulses once after the final beat is accepted.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   finish_mul_i         multiplier done level (launch on its rising edge)
//   n_dim_i, m_dim_i     result rows-1 / cols-1 (clamped to MAX_DIM-1)
//   base_addr_i          scratchpad base address of the result
//   c_matrix_i, flags_i  flattened result matrix and per-element overflow
//   wr_ready_i           sink accepts the current beat
//   wr_en_o, wr_addr_o,
//   wr_data_o            single-beat write port
//   flags_o              launch-time flags, out-of-range bits zeroed
//   busy_o               transfer in progress (WRITE or DONE)
//   finish_write_o       one-cycle completion pulse
// -----------------------------------------------------------------------------
module matmul_result_writer
  import matmul_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUS_WIDTH  = 16,
  parameter  int ADDR_WIDTH = 16,
  localparam int MAX_DIM    = max_dim(BUS_WIDTH, DATA_WIDTH)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 finish_mul_i,
  input  logic [1:0]                           n_dim_i,
  input  logic [1:0]                           m_dim_i,
  input  logic [ADDR_WIDTH-1:0]                base_addr_i,
  input  logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] c_matrix_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]           flags_i,
  input  logic                                 wr_ready_i,
  output logic                                 wr_en_o,
  output logic [ADDR_WIDTH-1:0]                wr_addr_o,
  output logic [BUS_WIDTH-1:0]                 wr_data_o,
  output logic [MAX_DIM*MAX_DIM-1:0]           flags_o,
  output logic                                 busy_o,
  output logic                                 finish_write_o
);

  localparam int NUM_ELEM = MAX_DIM * MAX_DIM;
  localparam int CNT_W    = cnt_width(MAX_DIM);
  localparam int DIM_MAX  = MAX_DIM - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t clamp_dim(input logic [1:0] d);
    if (int'(d) > DIM_MAX) return cnt_t'(DIM_MAX);
    return cnt_t'(d);
  endfunction

  wr_state_e                    r_state;
  logic                         r_fin_prev;
  logic [NUM_ELEM*BUS_WIDTH-1:0] r_c_mat;
  logic [NUM_ELEM-1:0]          r_flags;
  logic [ADDR_WIDTH-1:0]        r_base;
  cnt_t                         r_n_max;
  cnt_t                         r_m_max;
  cnt_t                         r_row;
  cnt_t                         r_col;
  logic                         r_wr_en;
  logic                         r_finish;

  cnt_t                         w_n_clamp;
  cnt_t                         w_m_clamp;
  logic [NUM_ELEM-1:0]          w_flags_masked;
  logic                         w_launch;
  logic                         w_accept;
  int                           w_elem_sel;
  logic [ADDR_WIDTH-1:0]        w_addr;

  assign w_n_clamp = clamp_dim(n_dim_i);
  assign w_m_clamp = clamp_dim(m_dim_i);

  // The previous-value register tracks finish_mul_i in every state, so a level
  // that stays high, or an edge seen while busy, never starts a transfer later.
  assign w_launch = finish_mul_i & ~r_fin_prev;
  assign w_accept = r_wr_en & wr_ready_i;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // otherwise paths that skip the assignment infer a latch.
  always_comb begin
    w_flags_masked = '0;
    for (int r = 0; r < MAX_DIM; r++) begin
      for (int c = 0; c < MAX_DIM; c++) begin
        if (r <= int'(w_n_clamp) && c <= int'(w_m_clamp)) begin
          w_flags_masked[flag_idx(r, c, MAX_DIM)] = flags_i[flag_idx(r, c, MAX_DIM)];
        end
      end
    end
  end

  // Address and data come only from registers, so they stay stable while the
  // sink holds wr_ready_i low. The address sum wraps at ADDR_WIDTH.
  assign w_elem_sel = elem_idx(int'(r_row), int'(r_col), MAX_DIM);
  assign w_addr     = r_base
                    + (ADDR_WIDTH'(r_row) * ADDR_WIDTH'(MAX_DIM))
                    + ADDR_WIDTH'(r_col);

  assign wr_en_o        = r_wr_en;
  assign wr_addr_o      = w_addr;
  assign wr_data_o      = r_c_mat[w_elem_sel*BUS_WIDTH +: BUS_WIDTH];
  assign flags_o        = r_flags;
  assign busy_o         = (r_state != ST_IDLE);
  assign finish_write_o = r_finish;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      // NOTE: the shadow bank is a plain register array (not a RAM macro), so
      // it is reset too; this keeps wr_data_o at zero out of reset.
      r_state    <= ST_IDLE;
      r_fin_prev <= 1'b0;
      r_c_mat    <= '0;
      r_flags    <= '0;
      r_base     <= '0;
      r_n_max    <= '0;
      r_m_max    <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_wr_en    <= 1'b0;
      r_finish   <= 1'b0;
    end else begin
      r_fin_prev <= finish_mul_i;
      r_finish   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_c_mat <= c_matrix_i;
            r_flags <= w_flags_masked;
            r_base  <= base_addr_i;
            r_n_max <= w_n_clamp;
            r_m_max <= w_m_clamp;
            r_row   <= '0;
            r_col   <= '0;
            r_wr_en <= 1'b1;
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_accept) begin
            if (r_col == r_m_max) begin
              r_col <= '0;
              if (r_row == r_n_max) begin
                r_wr_en  <= 1'b0;
                r_finish <= 1'b1;
                r_state  <= ST_DONE;
              end else begin
                r_row <= r_row + 1'b1;
              end
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_result_writer.sv
// -----------------------------------------------------------------------------
// tb_matmul_result_writer
// Self-checking bench for matmul_result_writer (default 2x2 configuration).
// A reference model expands each launch into the list of row-major write beats
// it must produce; a negedge monitor compares every accepted beat against that
// list and checks that a stalled beat holds still. Table vectors, random
// vectors and hand-written sequences (held level, re-pulse, reset) drive it.
// -----------------------------------------------------------------------------
module tb_matmul_result_writer;

  localparam int MAXD = 2;
  localparam int BW   = 16;
  localparam int AW   = 16;

  logic              clk;
  logic              rst_n;
  logic              finish_mul;
  logic [1:0]        n_dim;
  logic [1:0]        m_dim;
  logic [AW-1:0]     base_addr;
  logic [MAXD*MAXD*BW-1:0] c_matrix;
  logic [MAXD*MAXD-1:0]    flags_in;
  logic              wr_ready;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [BW-1:0]     wr_data;
  logic [MAXD*MAXD-1:0]    flags_out;
  logic              busy;
  logic              finish_write;

  matmul_result_writer #(
    .DATA_WIDTH(8),
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .finish_mul_i  (finish_mul),
    .n_dim_i       (n_dim),
    .m_dim_i       (m_dim),
    .base_addr_i   (base_addr),
    .c_matrix_i    (c_matrix),
    .flags_i       (flags_in),
    .wr_ready_i    (wr_ready),
    .wr_en_o       (wr_en),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .flags_o       (flags_out),
    .busy_o        (busy),
    .finish_write_o(finish_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Vectors and reference model. cm is indexed row-major: cm[r*2+c] = C(r,c).
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]        n;
    logic [1:0]        m;
    logic [AW-1:0]     base;
    logic [3:0]        flags;
    logic [3:0][BW-1:0] cm;
    int                stall_at;
    int                stall_len;
    bit                rand_ready;
    logic [3:0]        exp_flags;
    int                exp_beats;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    n_acc     = 0;
  int    fin_count = 0;

  function automatic vec_t mk(input logic [1:0] n, input logic [1:0] m, input logic [AW-1:0] base,
                              input logic [3:0] flags, input logic [3:0][BW-1:0] cm,
                              input int stall_at, input int stall_len,
                              input logic [3:0] exp_flags, input int exp_beats);
    vec_t v;
    v.n = n; v.m = m; v.base = base; v.flags = flags; v.cm = cm;
    v.stall_at = stall_at; v.stall_len = stall_len; v.rand_ready = 1'b0;
    v.exp_flags = exp_flags; v.exp_beats = exp_beats;
    return v;
  endfunction

  function automatic int eff_dim(input logic [1:0] d);
    return (int'(d) > MAXD - 1) ? MAXD - 1 : int'(d);
  endfunction

  function automatic int model_beats(input vec_t v);
    return (eff_dim(v.n) + 1) * (eff_dim(v.m) + 1);
  endfunction

  // Flag of element (r,c) lives at bit r + 2c and survives only inside the region.
  function automatic logic [3:0] model_flags(input vec_t v);
    logic [3:0] f = '0;
    for (int r = 0; r <= eff_dim(v.n); r++)
      for (int c = 0; c <= eff_dim(v.m); c++)
        f[r + 2*c] = v.flags[r + 2*c];
    return f;
  endfunction

  // Element (r,c) sits at slice c*2+r of the flattened bus.
  function automatic logic [MAXD*MAXD*BW-1:0] pack_c(input logic [3:0][BW-1:0] cm);
    logic [MAXD*MAXD*BW-1:0] res = '0;
    for (int r = 0; r < MAXD; r++)
      for (int c = 0; c < MAXD; c++)
        res[(c*MAXD + r)*BW +: BW] = cm[r*MAXD + c];
    return res;
  endfunction

  task automatic model_push(input vec_t v);
    beat_t b;
    for (int r = 0; r <= eff_dim(v.n); r++) begin
      for (int c = 0; c <= eff_dim(v.m); c++) begin
        b.addr = v.base + AW'(r*MAXD + c);
        b.data = v.cm[r*MAXD + c];
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic apply_inputs(input vec_t v);
    n_dim     = v.n;
    m_dim     = v.m;
    base_addr = v.base;
    flags_in  = v.flags;
    c_matrix  = pack_c(v.cm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: compares accepted beats with the model, checks stall stability.
  // ---------------------------------------------------------------------------
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr  = '0;
  logic [BW-1:0] prev_data  = '0;

  always @(negedge clk) begin
    beat_t b;
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_hold_en", wr_en, 1'b1);
        check("stall_hold_addr", wr_addr, prev_addr);
        check("stall_hold_data", wr_data, prev_data);
      end
      if (wr_en && wr_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat_addr", wr_addr, 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", wr_addr, b.addr);
          check("beat_data", wr_data, b.data);
          n_acc++;
        end
      end
      if (finish_write) fin_count++;
      prev_stall = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // One complete transfer: launch, scramble inputs after capture, drive ready,
  // then check latency, beat count, flags and the single finish pulse.
  // ---------------------------------------------------------------------------
  task automatic run_vec(input vec_t v, input string tag);
    int acc0    = n_acc;
    int fin0    = fin_count;
    int stalls  = 0;
    int stalled = 0;
    int j       = 0;
    apply_inputs(v);
    wr_ready = 1'b1;
    model_push(v);
    finish_mul = 1'b1;
    step();  // launch edge
    check({tag, "_wr_en_after_launch"}, wr_en, 1'b1);
    check({tag, "_busy_after_launch"}, busy, 1'b1);
    // Inputs may change freely once captured.
    n_dim     = 2'($urandom);
    m_dim     = 2'($urandom);
    base_addr = AW'($urandom);
    flags_in  = 4'($urandom);
    c_matrix  = {$urandom, $urandom};
    while (!finish_write && j < 200) begin
      if (v.rand_ready) wr_ready = ($urandom_range(0, 3) != 0);
      else wr_ready = !(wr_en && (n_acc - acc0) == v.stall_at && stalled < v.stall_len);
      if (wr_en && !wr_ready) begin
        stalls++;
        stalled++;
      end
      step();
      j++;
    end
    wr_ready = 1'b1;
    if (j >= 200) check({tag, "_finish_timeout"}, 32'(j), 32'(v.exp_beats + stalls));
    check({tag, "_finish_latency"}, 32'(j), 32'(v.exp_beats + stalls));
    check({tag, "_beats_accepted"}, 32'(n_acc - acc0), 32'(v.exp_beats));
    check({tag, "_flags_o"}, flags_out, v.exp_flags);
    check({tag, "_wr_en_low_in_done"}, wr_en, 1'b0);
    finish_mul = 1'b0;
    step();
    check({tag, "_finish_one_cycle"}, finish_write, 1'b0);
    check({tag, "_idle_not_busy"}, busy, 1'b0);
    check({tag, "_one_finish_pulse"}, 32'(fin_count - fin0), 32'd1);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  vec_t tbl[7];

  initial begin
    vec_t v;
    int   fin0;

    tbl[0] = mk(2'd1, 2'd1, 16'h0010, 4'b0000, {16'h7FFF, 16'h0007, 16'hFFFD, 16'h0005}, -1, 0, 4'b0000, 4);
    tbl[1] = mk(2'd0, 2'd1, 16'h0020, 4'b1111, {16'h1111, 16'h2222, 16'hABCD, 16'h1234}, -1, 0, 4'b0101, 2);
    tbl[2] = mk(2'd1, 2'd1, 16'h0100, 4'b1010, {16'hD00D, 16'hC00C, 16'hB00B, 16'hA00A},  1, 3, 4'b1010, 4);
    tbl[3] = mk(2'd1, 2'd1, 16'hFFFE, 4'b0000, {16'h0004, 16'h0003, 16'h0002, 16'h0001}, -1, 0, 4'b0000, 4);
    tbl[4] = mk(2'd3, 2'd2, 16'h0200, 4'b1111, {16'h8000, 16'h00FF, 16'hFF00, 16'h5A5A}, -1, 0, 4'b1111, 4);
    tbl[5] = mk(2'd1, 2'd0, 16'h0300, 4'b1111, {16'h0BAD, 16'hF00D, 16'hBEEF, 16'hCAFE}, -1, 0, 4'b0011, 2);
    tbl[6] = mk(2'd0, 2'd0, 16'h0400, 4'b1111, {16'h0000, 16'h0000, 16'h0000, 16'h8001},  0, 2, 4'b0001, 1);

    rst_n      = 1'b0;
    finish_mul = 1'b0;
    n_dim      = '0;
    m_dim      = '0;
    base_addr  = '0;
    c_matrix   = '0;
    flags_in   = '0;
    wr_ready   = 1'b1;
    #12;
    check("reset_wr_en", wr_en, 1'b0);
    check("reset_wr_addr", wr_addr, 16'h0);
    check("reset_wr_data", wr_data, 16'h0);
    check("reset_flags_o", flags_out, 4'h0);
    check("reset_busy", busy, 1'b0);
    check("reset_finish", finish_write, 1'b0);
    step();
    rst_n = 1'b1;
    step();

    // Table vectors.
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Held level launches once; a fall and rise launches again; a re-pulse
    // while busy is ignored.
    v = mk(2'd1, 2'd1, 16'h0040, 4'b0110, {16'h4444, 16'h3333, 16'h2222, 16'h1111}, -1, 0, 4'b0110, 4);
    apply_inputs(v);
    wr_ready = 1'b1;
    fin0 = fin_count;
    model_push(v);
    model_push(v);
    finish_mul = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("hold_level_single_transfer", 32'(fin_count - fin0), 32'd1);
    finish_mul = 1'b0;
    step();
    finish_mul = 1'b1;
    step();  // second launch edge
    check("relaunch_busy", busy, 1'b1);
    step();
    finish_mul = 1'b0;
    step();
    finish_mul = 1'b1;  // rises again while the transfer is running
    repeat (15) step();
    check("repulse_ignored_transfers", 32'(fin_count - fin0), 32'd2);
    check("repulse_queue_drained", 32'(exp_q.size()), 32'd0);
    finish_mul = 1'b0;
    step();

    // Reset during the second beat abandons the transfer without a finish pulse.
    v = mk(2'd1, 2'd1, 16'h0033, 4'b1111, {16'h0D0D, 16'h0C0C, 16'h0B0B, 16'h0A0A}, -1, 0, 4'b1111, 4);
    apply_inputs(v);
    fin0 = fin_count;
    model_push(v);
    finish_mul = 1'b1;
    step();  // launch edge
    step();  // first beat accepted, second beat on the bus
    check("pre_reset_wr_en", wr_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_wr_en", wr_en, 1'b0);
    check("async_reset_wr_addr", wr_addr, 16'h0);
    check("async_reset_wr_data", wr_data, 16'h0);
    check("async_reset_flags_o", flags_out, 4'h0);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_finish", finish_write, 1'b0);
    exp_q.delete();
    finish_mul = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) step();
    check("reset_no_finish_pulse", 32'(fin_count - fin0), 32'd0);
    run_vec(v, "post_reset");

    // Random vectors with random backpressure.
    for (int i = 0; i < 20; i++) begin
      v = mk(2'($urandom), 2'($urandom), AW'($urandom), 4'($urandom),
             {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, -1, 0, 4'b0, 0);
      v.rand_ready = 1'b1;
      v.exp_flags  = model_flags(v);
      v.exp_beats  = model_beats(v);
      run_vec(v, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
